graycounter_16_reader: RTL and testbench
========================================

# graycounter_16_reader

Read-side endpoint for the 16-state Gray pointer that the PCS writer domain produces with its 5-bit Gray counter.
- Synchronizes the incoming write pointer into the local clock and decodes it to binary.
- Keeps a local 16-state read pointer and publishes it back in the same 5-bit Gray encoding.
- Reports occupancy, empty, and protocol errors for the elastic buffer between the two domains.

## Interface
Parameters:
- SYNC_STAGES, 2, flops in the write-pointer synchronizer chain (legal values ≥2).

Ports:
- clk  in  1  single clock.
- reset  in  1  synchronous, active-high reset.
- wr_gray_async  in  5  writer's Gray pointer, asynchronous to clk.
- rd_en  in  1  request to consume one entry.
- clear_err  in  1  clears err_sticky.
- wr_bin  out  4  decoded, synchronized write pointer.
- rd_bin  out  4  local read pointer, binary.
- rd_gray  out  5  local read pointer, Gray; bit4 is always 0.
- level  out  4  occupancy, equal to (wr_bin − rd_bin) mod 16.
- empty  out  1  high when level==0.
- ovf  out  1  one-cycle pulse: the writer overran the reader.
- illegal  out  1  one-cycle pulse: an invalid code was received.
- err_sticky  out  1  set on ovf or illegal; cleared by clear_err.

## Operation
- Code set: 4-bit reflected Gray sequence 00000, 00001, 00011, 00010, 00110, 00111, 00101, 00100, 01100, 01101, 01111, 01110, 01010, 01011, 01001, 01000, then back to 00000. Any code with bit4=1 is illegal.
- Decode: b3=g3, bi=b(i+1)^gi.
- Synchronizer output `gs` is evaluated every cycle, after the mask window (see below).
  - Illegal code: illegal pulses; wr_bin holds.
  - Otherwise: wr_bin loads decode(gs). Define adv=(new−old) mod 16. If level+adv>15, ovf pulses and the new value is still loaded.
- Multi-step advances are legal when the writer clock is faster than clk. Only the overflow rule applies to them.
- Read:
  - rd_en && !empty: rd_bin increments mod 16, and rd_gray takes the Gray code of the new value on the same edge.
  - rd_en && empty: ignored, with no error.
- Overflow check uses the pre-edge level and rd_bin. A read on the same edge does not suppress ovf.
- The next level is computed from the updated wr_bin and rd_bin. level and empty are combinational from the registers.
- err_sticky: set wins over a simultaneous clear_err.
- Post-reset mask: for SYNC_STAGES+1 cycles after reset falls, wr_bin loads decode(gs) directly and ovf/illegal are suppressed.
  - An illegal code inside the window loads 0.
  - The mask is implemented as a small down-counter.

## Timing
- Reset (on a clk edge with reset=1): sync chain, wr_bin, rd_bin, rd_gray, and the mask counter load their reset values.
  - Reset values: level=0, empty=1, ovf=0, illegal=0, err_sticky=0, rd_gray=00000.
  - The mask counter loads SYNC_STAGES+1.
- Reset mid-operation: every register returns to its reset value on the next edge, discarding in-flight synchronizer data.
- Write latency: a stable change on wr_gray_async appears on wr_bin, level, and empty SYNC_STAGES+1 edges later. ovf and illegal pulse in that same cycle.
- Read latency: rd_bin, rd_gray, and level update on the edge that samples rd_en. rd_gray then changes exactly one bit per step.
- Wrap-around:
  - rd_bin 15→0, with rd_gray going 01000→00000.
  - wr_bin 15→0 gives no error when level permits.

## Structure
- Shared package `pcs_gray_pkg` holds:
  - constants G0..G15, PTR_W=4, CODE_W=5;
  - functions gray2bin and bin2gray;
  - illegal-code predicate (bit4 set).
- Sub-module `gray_ptr_sync`: parameterized SYNC_STAGES × 5-bit flop chain with synchronous reset, no logic between stages.
- Top level holds the decode, adv/ovf arithmetic (5-bit sum for level+adv), read pointer, mask counter, and error flags.

## Test plan
- Reset, then hold wr_gray_async=00001 → wr_bin=1, level=1, and empty=0 exactly 3 edges later (SYNC_STAGES=2); no error.
- Step the writer through all 16 codes and wrap to 00000 while pulsing rd_en after each arrival → rd_gray walks 00000..01000 and back to 00000, level never exceeds 1, err_sticky=0.
- Apply rd_en with level=0 → rd_bin=0, rd_gray=00000, no pulse.
- Bring level to 12 (wr_bin=12, rd_bin=0), then change the input 01010→00011 (adv=6) → ovf pulse, err_sticky=1, wr_bin=2; assert clear_err → err_sticky=0 next edge.
- Drive 10000 after mask expiry → illegal pulses once, wr_bin holds; a simultaneous clear_err leaves err_sticky=1.
- Reach level=7, assert reset for 1 cycle while the input is 00101, then release → all outputs at reset values. The mask window loads wr_bin=6 with no ovf.

Source files
------------

// File: rtl/pcs_gray_pkg.sv
// Shared Gray-pointer definitions for the PCS elastic buffer: code constants,
// encode/decode helpers and the illegal-code predicate.
package pcs_gray_pkg;

  localparam int PTR_W  = 4;
  localparam int CODE_W = 5;

  localparam logic [CODE_W-1:0] G0  = 5'b00000;
  localparam logic [CODE_W-1:0] G1  = 5'b00001;
  localparam logic [CODE_W-1:0] G2  = 5'b00011;
  localparam logic [CODE_W-1:0] G3  = 5'b00010;
  localparam logic [CODE_W-1:0] G4  = 5'b00110;
  localparam logic [CODE_W-1:0] G5  = 5'b00111;
  localparam logic [CODE_W-1:0] G6  = 5'b00101;
  localparam logic [CODE_W-1:0] G7  = 5'b00100;
  localparam logic [CODE_W-1:0] G8  = 5'b01100;
  localparam logic [CODE_W-1:0] G9  = 5'b01101;
  localparam logic [CODE_W-1:0] G10 = 5'b01111;
  localparam logic [CODE_W-1:0] G11 = 5'b01110;
  localparam logic [CODE_W-1:0] G12 = 5'b01010;
  localparam logic [CODE_W-1:0] G13 = 5'b01011;
  localparam logic [CODE_W-1:0] G14 = 5'b01001;
  localparam logic [CODE_W-1:0] G15 = 5'b01000;

  function automatic logic [PTR_W-1:0] gray2bin(input logic [CODE_W-1:0] g);
    logic [PTR_W-1:0] b;
    b[PTR_W-1] = g[PTR_W-1];
    for (int i = PTR_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Bit4 of the code is never set by a healthy writer.
  function automatic logic [CODE_W-1:0] bin2gray(input logic [PTR_W-1:0] b);
    return {1'b0, b ^ (b >> 1)};
  endfunction

  function automatic logic is_illegal_code(input logic [CODE_W-1:0] g);
    return g[CODE_W-1];
  endfunction

endpackage

// File: rtl/gray_ptr_sync.sv
// Plain flop chain bringing the writer's Gray pointer into the local clock.
module gray_ptr_sync
  import pcs_gray_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [CODE_W-1:0] d_async,
  output logic [CODE_W-1:0] q
);

  logic [CODE_W-1:0] stage_q [SYNC_STAGES];
  logic [CODE_W-1:0] stage_d [SYNC_STAGES];

  always_comb begin
    stage_d[0] = d_async;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < SYNC_STAGES; i++) begin
      if (reset) stage_q[i] <= '0;
      else       stage_q[i] <= stage_d[i];
    end
  end

  assign q = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/graycounter_16_reader.sv
// Read-side endpoint of the 16-state Gray pointer: synchronizes and decodes the
// write pointer, owns the read pointer, and flags occupancy and protocol errors.
module graycounter_16_reader
  import pcs_gray_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [CODE_W-1:0] wr_gray_async,
  input  logic              rd_en,
  input  logic              clear_err,
  output logic [PTR_W-1:0]  wr_bin,
  output logic [PTR_W-1:0]  rd_bin,
  output logic [CODE_W-1:0] rd_gray,
  output logic [PTR_W-1:0]  level,
  output logic              empty,
  output logic              ovf,
  output logic              illegal,
  output logic              err_sticky
);

  localparam int                MASK_W    = $clog2(SYNC_STAGES + 2);
  localparam logic [MASK_W-1:0] MASK_INIT = MASK_W'(SYNC_STAGES + 1);

  logic [CODE_W-1:0] gs;
  logic [PTR_W-1:0]  wr_bin_q, wr_bin_d, rd_bin_q, rd_bin_d;
  logic [CODE_W-1:0] rd_gray_q, rd_gray_d;
  logic [MASK_W-1:0] mask_cnt_q, mask_cnt_d;
  logic              ovf_q, ovf_d, illegal_q, illegal_d, err_q, err_d;
  logic              masked, code_bad, rd_fire;
  logic [PTR_W-1:0]  dec, adv, level_w;
  logic [PTR_W:0]    lvl_sum;

  gray_ptr_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk     (clk),
    .reset   (reset),
    .d_async (wr_gray_async),
    .q       (gs)
  );

  assign level_w = wr_bin_q - rd_bin_q;

  // rd_en is a request, not a handshake: it is consumed only when not empty
  // and is silently dropped otherwise.
  always_comb begin
    masked     = (mask_cnt_q != '0);
    code_bad   = is_illegal_code(gs);
    dec        = gray2bin(gs);
    adv        = dec - wr_bin_q;
    lvl_sum    = {1'b0, level_w} + {1'b0, adv};
    wr_bin_d   = wr_bin_q;
    mask_cnt_d = mask_cnt_q;
    ovf_d      = 1'b0;
    illegal_d  = 1'b0;
    if (masked) begin
      wr_bin_d   = code_bad ? '0 : dec;
      mask_cnt_d = mask_cnt_q - 1'b1;
    end else if (code_bad) begin
      illegal_d  = 1'b1;
    end else begin
      wr_bin_d   = dec;
      ovf_d      = lvl_sum[PTR_W];
    end

    rd_fire   = rd_en && (level_w != '0);
    rd_bin_d  = rd_bin_q;
    rd_gray_d = rd_gray_q;
    if (rd_fire) begin
      rd_bin_d  = rd_bin_q + 1'b1;
      rd_gray_d = bin2gray(rd_bin_d);
    end

    // A new error on this edge outranks a clear request.
    err_d = err_q;
    if (ovf_d || illegal_d) err_d = 1'b1;
    else if (clear_err)     err_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_bin_q   <= '0;
      rd_bin_q   <= '0;
      rd_gray_q  <= '0;
      mask_cnt_q <= MASK_INIT;
      ovf_q      <= 1'b0;
      illegal_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      wr_bin_q   <= wr_bin_d;
      rd_bin_q   <= rd_bin_d;
      rd_gray_q  <= rd_gray_d;
      mask_cnt_q <= mask_cnt_d;
      ovf_q      <= ovf_d;
      illegal_q  <= illegal_d;
      err_q      <= err_d;
    end
  end

  assign wr_bin     = wr_bin_q;
  assign rd_bin     = rd_bin_q;
  assign rd_gray    = rd_gray_q;
  assign level      = level_w;
  assign empty      = (level_w == '0);
  assign ovf        = ovf_q;
  assign illegal    = illegal_q;
  assign err_sticky = err_q;

endmodule

// File: tb/tb_graycounter_16_reader.sv
// Directed bench for graycounter_16_reader with hand-computed expectations.
module tb_graycounter_16_reader;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] wr_gray_async;
  logic       rd_en;
  logic       clear_err;
  logic [3:0] wr_bin, rd_bin, level;
  logic [4:0] rd_gray;
  logic       empty, ovf, illegal, err_sticky;

  int n_vec = 0;
  int n_mis = 0;

  logic [4:0] gray_tab [16] = '{5'b00000, 5'b00001, 5'b00011, 5'b00010,
                                5'b00110, 5'b00111, 5'b00101, 5'b00100,
                                5'b01100, 5'b01101, 5'b01111, 5'b01110,
                                5'b01010, 5'b01011, 5'b01001, 5'b01000};
  logic [4:0] exp_q [$];

  graycounter_16_reader #(.SYNC_STAGES(2)) dut (
    .clk           (clk),
    .reset         (reset),
    .wr_gray_async (wr_gray_async),
    .rd_en         (rd_en),
    .clear_err     (clear_err),
    .wr_bin        (wr_bin),
    .rd_bin        (rd_bin),
    .rd_gray       (rd_gray),
    .level         (level),
    .empty         (empty),
    .ovf           (ovf),
    .illegal       (illegal),
    .err_sticky    (err_sticky)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic read_one();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".wr_bin"},  16'(wr_bin), 16'h0);
    check({tag, ".rd_bin"},  16'(rd_bin), 16'h0);
    check({tag, ".rd_gray"}, 16'(rd_gray), 16'h0);
    check({tag, ".level"},   16'(level), 16'h0);
    check({tag, ".empty"},   16'(empty), 16'h1);
    check({tag, ".ovf"},     16'(ovf), 16'h0);
    check({tag, ".illegal"}, 16'(illegal), 16'h0);
    check({tag, ".err"},     16'(err_sticky), 16'h0);
  endtask

  initial begin
    reset = 1'b1;
    wr_gray_async = 5'b00000;
    rd_en = 1'b0;
    clear_err = 1'b0;
    tick(2);
    check_reset_state("rst");

    // Write latency: three edges after release.
    wr_gray_async = 5'b00001;
    reset = 1'b0;
    tick(2);
    check("lat.early_wr_bin", 16'(wr_bin), 16'h0);
    tick();
    check("lat.wr_bin", 16'(wr_bin), 16'h1);
    check("lat.level",  16'(level), 16'h1);
    check("lat.empty",  16'(empty), 16'h0);
    check("lat.err",    16'(err_sticky), 16'h0);

    // Walk all codes with a read after each arrival, including both wraps.
    for (int i = 1; i <= 16; i++) exp_q.push_back(gray_tab[i % 16]);
    read_one();
    check("walk.rd_gray1", 16'(rd_gray), 16'(exp_q.pop_front()));
    for (int i = 2; i <= 16; i++) begin
      wr_gray_async = gray_tab[i % 16];
      tick(3);
      check($sformatf("walk.wr_bin%0d", i), 16'(wr_bin), 16'(i % 16));
      check($sformatf("walk.level%0d", i), 16'(level), 16'h1);
      read_one();
      check($sformatf("walk.rd_gray%0d", i), 16'(rd_gray), 16'(exp_q.pop_front()));
      check($sformatf("walk.lvl0_%0d", i), 16'(level), 16'h0);
    end
    check("walk.err", 16'(err_sticky), 16'h0);

    // Read while empty is ignored.
    read_one();
    check("emptyrd.rd_bin",  16'(rd_bin), 16'h0);
    check("emptyrd.rd_gray", 16'(rd_gray), 16'h0);
    check("emptyrd.ovf",     16'(ovf), 16'h0);
    check("emptyrd.illegal", 16'(illegal), 16'h0);
    check("emptyrd.empty",   16'(empty), 16'h1);

    // Overflow: level 12 then a 6-step advance.
    wr_gray_async = 5'b01010;
    tick(3);
    check("ovf.pre_wr_bin", 16'(wr_bin), 16'd12);
    check("ovf.pre_level",  16'(level), 16'd12);
    check("ovf.pre_ovf",    16'(ovf), 16'h0);
    wr_gray_async = 5'b00011;
    tick(2);
    check("ovf.not_yet", 16'(ovf), 16'h0);
    tick();
    check("ovf.pulse",  16'(ovf), 16'h1);
    check("ovf.err",    16'(err_sticky), 16'h1);
    check("ovf.wr_bin", 16'(wr_bin), 16'd2);
    check("ovf.level",  16'(level), 16'd2);
    tick();
    check("ovf.once", 16'(ovf), 16'h0);
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    check("ovf.cleared", 16'(err_sticky), 16'h0);

    // One-cycle illegal code; clear_err on the detecting edge loses.
    wr_gray_async = 5'b10000;
    tick();
    wr_gray_async = 5'b00011;
    tick();
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    check("ill.pulse",  16'(illegal), 16'h1);
    check("ill.wr_bin", 16'(wr_bin), 16'd2);
    check("ill.err",    16'(err_sticky), 16'h1);
    check("ill.ovf",    16'(ovf), 16'h0);
    tick();
    check("ill.once",     16'(illegal), 16'h0);
    check("ill.err_hold", 16'(err_sticky), 16'h1);
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    check("ill.cleared", 16'(err_sticky), 16'h0);

    // Reach level 7, then reset mid-operation.
    wr_gray_async = 5'b00100;
    tick(3);
    check("rst2.pre_level", 16'(level), 16'd7);
    wr_gray_async = 5'b00101;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_reset_state("rst2");
    tick(2);
    check("mask.early", 16'(wr_bin), 16'h0);
    tick();
    check("mask.wr_bin", 16'(wr_bin), 16'd6);
    check("mask.level",  16'(level), 16'd6);
    check("mask.ovf",    16'(ovf), 16'h0);
    check("mask.err",    16'(err_sticky), 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
